// File: rtl/mtr_drv_pwm.sv
// Dual-channel H-bridge PWM: signed speed -> shadowed duty -> complementary pair with dead-time.
// Outputs are registered and show the state of the previous count of the shared 2048-clock period.
module mtr_drv_pwm #(
    parameter int DEADTIME = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic signed [10:0] lft_spd,
    input  logic signed [10:0] rght_spd,
    output logic               lftPWM1,
    output logic               lftPWM2,
    output logic               rghtPWM1,
    output logic               rghtPWM2,
    output logic               pwm_sync
);
    localparam logic [7:0]  DT       = 8'(DEADTIME);
    localparam logic [10:0] CNT_MAX  = 11'h7FF;
    localparam logic [10:0] DUTY_RST = 11'h400;

    // Offset-binary conversion: adding 1024 is the same as flipping the sign bit.
    function automatic logic [10:0] spd_to_duty(input logic signed [10:0] spd);
        return {~spd[10], spd[9:0]};
    endfunction

    function automatic logic [7:0] dt_sat_inc(input logic [7:0] dt);
        logic [8:0] v_inc;
        v_inc = {1'b0, dt} + 9'd1;
        return (v_inc >= {1'b0, DT}) ? DT : v_inc[7:0];
    endfunction

    logic        [10:0] r_cnt_p0;
    logic [1:0]  [10:0] r_duty_p0;
    logic [1:0]         r_raw_prev_p0;
    logic [1:0]  [7:0]  r_dt_p0;
    logic [1:0]         r_pwm1_p1;
    logic [1:0]         r_pwm2_p1;
    logic               r_sync_p1;

    logic [1:0]  [10:0] w_duty_in;
    logic [1:0]         w_raw;
    logic [1:0]  [7:0]  w_dt;
    logic [1:0]         w_dt_done;

    assign w_duty_in[0] = spd_to_duty(lft_spd);
    assign w_duty_in[1] = spd_to_duty(rght_spd);

    // Stage p0: raw compare and dead-time tracking for the current count (index 0 = left, 1 = right).
    always_comb begin
        w_raw     = '0;
        w_dt      = '0;
        w_dt_done = '0;
        for (int c = 0; c < 2; c++) begin
            w_raw[c]     = (r_cnt_p0 < r_duty_p0[c]);
            w_dt[c]      = ((r_cnt_p0 < r_duty_p0[c]) != r_raw_prev_p0[c]) ? 8'd0
                                                                          : dt_sat_inc(r_dt_p0[c]);
            w_dt_done[c] = (w_dt[c] == DT);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt_p0      <= '0;
            r_duty_p0     <= {DUTY_RST, DUTY_RST};
            r_raw_prev_p0 <= '0;
            r_dt_p0       <= '0;
            r_pwm1_p1     <= '0;
            r_pwm2_p1     <= '0;
            r_sync_p1     <= 1'b0;
        end else begin
            r_cnt_p0 <= r_cnt_p0 + 11'd1;
            // Duty only changes on the last count so a period is never split between two values.
            if (r_cnt_p0 == CNT_MAX) begin
                r_duty_p0 <= w_duty_in;
            end
            r_raw_prev_p0 <= w_raw;
            r_dt_p0       <= w_dt;
            // Stage p1: registered bridge drives aligned with pwm_sync.
            r_pwm1_p1     <= w_raw & w_dt_done;
            r_pwm2_p1     <= ~w_raw & w_dt_done;
            r_sync_p1     <= (r_cnt_p0 == 11'd0);
        end
    end

    assign lftPWM1  = r_pwm1_p1[0];
    assign lftPWM2  = r_pwm2_p1[0];
    assign rghtPWM1 = r_pwm1_p1[1];
    assign rghtPWM2 = r_pwm2_p1[1];
    assign pwm_sync = r_sync_p1;

endmodule

// File: tb/tb_mtr_drv_pwm.sv
// Scoreboard bench for mtr_drv_pwm: three instances (dead-time 1, 32, 255) share clock, reset and speeds.
// A count-by-count reference model pushes expected outputs; they are popped when the DUT registers them.
module tb_mtr_drv_pwm;
    localparam int NI = 3;
    localparam int TV [NI] = '{1, 32, 255};

    logic               clk = 1'b0;
    logic               rst;
    logic signed [10:0] lft_spd;
    logic signed [10:0] rght_spd;
    logic [NI-1:0]      o_l1, o_l2, o_r1, o_r2, o_sync;

    always #5 clk = ~clk;

    for (genvar g = 0; g < NI; g++) begin : g_dut
        mtr_drv_pwm #(.DEADTIME(TV[g])) u_dut (
            .clk      (clk),
            .rst      (rst),
            .lft_spd  (lft_spd),
            .rght_spd (rght_spd),
            .lftPWM1  (o_l1[g]),
            .lftPWM2  (o_l2[g]),
            .rghtPWM1 (o_r1[g]),
            .rghtPWM2 (o_r2[g]),
            .pwm_sync (o_sync[g])
        );
    end

    int          n_chk = 0;
    int          n_err = 0;
    int          m_cnt;
    int          m_sh [2];
    bit          m_prev [NI][2];
    int          m_dt [NI][2];
    logic [14:0] sb_q [$];
    int          last_k;
    int          pd [2];
    int          hi [NI][4];
    int          first [NI][4];
    int          last [NI][4];
    int          nsync [NI];
    int          runlow [NI][2];
    logic [1:0]  prevpair [NI][2];

    task automatic chk(input string tag, input int obs, input int want);
        n_chk++;
        if (obs != want) begin
            n_err++;
            $display("FAIL %s got %0h want %0h (t=%0t)", tag, obs, want, $time);
        end
    endtask

    // Per instance: {sync, l1, l2, r1, r2}
    function automatic logic [14:0] act_vec();
        logic [14:0] v;
        v = '0;
        for (int i = 0; i < NI; i++) v[i*5 +: 5] = {o_sync[i], o_l1[i], o_l2[i], o_r1[i], o_r2[i]};
        return v;
    endfunction

    task automatic model_reset();
        m_cnt   = 0;
        m_sh[0] = 1024;
        m_sh[1] = 1024;
        for (int i = 0; i < NI; i++) begin
            for (int c = 0; c < 2; c++) begin
                m_prev[i][c]   = 1'b0;
                m_dt[i][c]     = 0;
                runlow[i][c]   = 0;
                prevpair[i][c] = 2'b00;
            end
        end
        sb_q.delete();
    endtask

    task automatic tick();
        logic [14:0] e;
        logic [14:0] a;
        logic [3:0]  o;
        logic [1:0]  pair;
        int          k, t, d, nd, w;
        bit          raw;
        k = m_cnt;
        e = '0;
        if (k == 0) begin
            pd[0] = m_sh[0];
            pd[1] = m_sh[1];
        end
        for (int i = 0; i < NI; i++) begin
            t = TV[i];
            for (int c = 0; c < 2; c++) begin
                raw = (k < m_sh[c]);
                if (raw != m_prev[i][c]) nd = 0;
                else                     nd = (m_dt[i][c] + 1 > t) ? t : m_dt[i][c] + 1;
                m_prev[i][c] = raw;
                m_dt[i][c]   = nd;
                e[i*5 + 3 - 2*c] = raw && (nd == t);
                e[i*5 + 2 - 2*c] = !raw && (nd == t);
            end
            e[i*5 + 4] = (k == 0);
        end
        sb_q.push_back(e);
        if (k == 2047) begin
            m_sh[0] = int'(lft_spd) + 1024;
            m_sh[1] = int'(rght_spd) + 1024;
        end
        m_cnt = (k + 1) % 2048;

        @(posedge clk);
        #1;
        a = act_vec();
        e = sb_q.pop_front();
        chk("outs", a, e);

        for (int i = 0; i < NI; i++) begin
            t = TV[i];
            o = a[i*5 +: 4];
            if (k == 0) begin
                nsync[i] = 0;
                for (int j = 0; j < 4; j++) begin
                    hi[i][j]    = 0;
                    first[i][j] = -1;
                    last[i][j]  = -1;
                end
            end
            if (a[i*5 + 4]) nsync[i]++;
            for (int j = 0; j < 4; j++) begin
                if (o[3-j]) begin
                    hi[i][j]++;
                    if (first[i][j] < 0) first[i][j] = k;
                    last[i][j] = k;
                end
            end
            for (int c = 0; c < 2; c++) begin
                pair = 2'(o >> (2 - 2*c));
                chk($sformatf("overlap_t%0d_c%0d", t, c), int'(&pair), 0);
                if (pair == 2'b00) begin
                    runlow[i][c]++;
                end else begin
                    if (pair != prevpair[i][c])
                        chk($sformatf("dt_gap_t%0d_c%0d", t, c),
                            (runlow[i][c] < t) ? runlow[i][c] : t, t);
                    runlow[i][c] = 0;
                end
                prevpair[i][c] = pair;
            end
            if (k == 2047) begin
                chk($sformatf("sync_per_t%0d", t), nsync[i], 1);
                for (int c = 0; c < 2; c++) begin
                    d = pd[c];
                    chk($sformatf("hi_pwm1_t%0d_c%0d", t, c), hi[i][2*c], (d > t) ? d - t : 0);
                    if (d > 0) begin
                        w = 2048 - d - t;
                        chk($sformatf("hi_pwm2_t%0d_c%0d", t, c), hi[i][2*c+1], (w > 0) ? w : 0);
                    end
                end
            end
        end
        last_k = k;
    endtask

    task automatic run_period();
        int n;
        n = 0;
        do begin
            tick();
            n++;
        end while (last_k != 2047 && n < 2100);
        if (last_k != 2047) chk("period_timeout", last_k, 2047);
    endtask

    task automatic run_to(input int target);
        int n;
        n = 0;
        while (m_cnt != target && n < 2100) begin
            tick();
            n++;
        end
        if (m_cnt != target) chk("run_to_timeout", m_cnt, target);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog got running want finished");
        $fatal(1, "watchdog");
    end

    initial begin
        rst      = 1'b1;
        lft_spd  = '0;
        rght_spd = '0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        chk("rst_state", act_vec(), 0);
        rst = 1'b0;

        // Stop: both speeds zero, first period after reset
        run_period();
        chk("stop_l1_first", first[1][0], 32);
        chk("stop_l1_last",  last[1][0],  1023);
        chk("stop_l1_hi",    hi[1][0],    992);
        chk("stop_l2_first", first[1][1], 1056);
        chk("stop_l2_last",  last[1][1],  2047);
        chk("stop_l2_hi",    hi[1][1],    992);

        // Full forward on the right channel
        rght_spd = 11'sd1023;
        run_period();
        run_period();
        chk("fwd_r1_first", first[1][2], 32);
        chk("fwd_r1_last",  last[1][2],  2046);
        chk("fwd_r1_hi",    hi[1][2],    2015);
        chk("fwd_r2_hi",    hi[1][3],    0);

        // Full reverse on the right channel: steady state is PWM2 continuously high
        rght_spd = -11'sd1024;
        run_period();
        run_period();
        run_period();
        chk("rev_r1_hi",    hi[1][2],    0);
        chk("rev_r2_first", first[1][3], 0);
        chk("rev_r2_last",  last[1][3],  2047);
        chk("rev_r2_hi",    hi[1][3],    2048);

        // Mid-period update is deferred to the next period
        run_to(500);
        lft_spd = 11'sd512;
        run_period();
        chk("mid_cur_l1_last", last[1][0], 1023);
        run_period();
        chk("mid_nxt_l1_first", first[1][0], 32);
        chk("mid_nxt_l1_last",  last[1][0],  1535);
        chk("mid_nxt_l1_hi",    hi[1][0],    1504);
        chk("mid_nxt_l2_first", first[1][1], 1568);
        chk("mid_nxt_l2_last",  last[1][1],  2047);

        // Random sweep, with the extremes forced on the first two periods
        for (int p = 0; p < 8; p++) begin
            if (p == 0) begin
                lft_spd  = 11'sd1023;
                rght_spd = -11'sd1024;
            end else if (p == 1) begin
                lft_spd  = -11'sd1024;
                rght_spd = 11'sd1023;
            end else begin
                lft_spd  = 11'($urandom_range(2047, 0));
                rght_spd = 11'($urandom_range(2047, 0));
            end
            run_to(1000 + 50 * p);
            run_period();
        end

        // Reset in the middle of a PWM1-high stretch
        lft_spd  = 11'sd512;
        rght_spd = 11'sd0;
        run_period();
        run_to(1500);
        chk("pre_rst_l1", o_l1[1], 1);
        #2 rst = 1'b1;
        #1;
        chk("rst_async", act_vec(), 0);
        model_reset();
        @(posedge clk);
        #1;
        chk("rst_hold", act_vec(), 0);
        rst = 1'b0;
        run_period();
        chk("rst_l1_first", first[1][0], 32);
        chk("rst_l1_last",  last[1][0],  1023);
        chk("rst_l1_hi",    hi[1][0],    992);
        chk("rst_l2_first", first[1][1], 1056);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
